// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/moc_watchdog.sv
// Counts cycles an access has been waiting for MOC. `expired` is high on the
// edge at which the count would reach TIMEOUT, so MOV is high for exactly
// TIMEOUT cycles before the arbiter gives up.
module moc_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Cycle counter: cleared on each grant, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and data
// load/store. Latches the winner's request, drives the MOV/RW handshake,
// returns data with a one-cycle ack and aborts accesses whose MOC never comes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_mov,
  output logic          mem_rw,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_moc,
  output logic          err,
  output logic          busy_d
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic last_d_q;
  logic grant;
  logic grant_d;
  logic done_ok;
  logic done_to;
  logic wd_clear;
  logic wd_en;
  logic wd_expired;

  moc_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_expired)
  );

  // State register; reset mid-access drops straight back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision; a tie goes to the port not served last.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_d  = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant    = 1'b1;
          grant_d  = d_req && (!i_req || !last_d_q);
          wd_clear = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wd_en = 1'b1;
        if (mem_moc) begin
          done_ok = 1'b1;
          state_d = DONE;
        end else if (wd_expired) begin
          done_to = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the winner's request so the memory sees stable values for the
  // whole access; fetch is always a word read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_mov   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy_d    <= 1'b0;
      last_d_q  <= 1'b1;
    end else begin
      mem_mov <= (state_d == BUSY);
      if (grant) begin
        busy_d   <= grant_d;
        last_d_q <= grant_d;
        if (grant_d) begin
          mem_rw    <= d_rw;
          mem_size  <= d_size;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_rw    <= RW_READ;
          mem_size  <= SZ_WORD;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end
    end
  end

  // Completion: one-cycle ack to the winner, err only on a genuine timeout,
  // read data captured only when MOC actually arrived on a read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      if (done_ok || done_to) begin
        if (busy_d) begin
          d_ack <= 1'b1;
        end else begin
          i_ack <= 1'b1;
        end
        err <= done_to;
      end
      if (done_ok && (mem_rw == RW_READ)) begin
        if (busy_d) begin
          d_rdata <= mem_rdata;
        end else begin
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a RAM model with programmable MOC
// delay, a scoreboard of expected acks, a table of single accesses and
// hand-written sequences for ties and reset during an access.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_rw;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_mov;
  logic          mem_rw;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_moc;
  logic          err;
  logic          busy_d;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic          port_d;
    logic [DW-1:0] rdata;
    logic          err;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  typedef struct {
    logic          port_d;
    logic          rw;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ram;
    int            delay;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_mov;
  } vec_t;

  vec_t vecs[8];

  int            moc_delay = 0;
  logic          use_fixed = 1'b1;
  logic [DW-1:0] ram_word  = '0;
  int            wait_cnt  = 0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_moc(mem_moc), .err(err), .busy_d(busy_d)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // RAM model: raises MOC moc_delay cycles after first seeing MOV, holds it
  // until MOV falls.
  initial begin
    mem_moc   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_mov) begin
        if (wait_cnt == moc_delay) begin
          mem_moc   = 1'b1;
          mem_rdata = use_fixed ? ram_word : ram_fn(mem_addr);
        end
        wait_cnt++;
      end else begin
        mem_moc  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: every ack pops the next expected completion.
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_ack", 128'({i_ack, d_ack}), 128'(2'b00));
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("ack_port", 128'({i_ack, d_ack}), mon_e.port_d ? 128'(2'b01) : 128'(2'b10));
        checkOutput("ack_rdata", 128'(mon_e.port_d ? d_rdata : i_rdata), 128'(mon_e.rdata));
        checkOutput("ack_err", 128'(err), 128'(mon_e.err));
      end
    end else if (err) begin
      checkOutput("err_without_ack", 128'(err), 128'(1'b0));
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    int            lat = 0;
    int            mov = 0;
    bit            got = 1'b0;
    logic [AW+2:0] exp_ctl;
    moc_delay = v.delay;
    ram_word  = v.ram;
    use_fixed = 1'b1;
    exp_ctl   = v.port_d ? {v.rw, v.size, v.addr} : {RW_READ, SZ_WORD, v.addr};
    if (v.port_d) begin
      d_req = 1'b1; d_rw = v.rw; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    sb_q.push_back('{v.port_d, v.exp_rdata, v.exp_err});
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (i_ack || d_ack) begin
        got = 1'b1;
      end else if (mem_mov) begin
        mov++;
        checkOutput($sformatf("v%0d_mem_ctl", idx), 128'({mem_rw, mem_size, mem_addr}), 128'(exp_ctl));
        if (v.port_d) checkOutput($sformatf("v%0d_mem_wdata", idx), 128'(mem_wdata), 128'(v.wdata));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_rw    = 1'($urandom);
        d_size  = 2'($urandom);
        i_addr  = $urandom;
      end
    end
    checkOutput($sformatf("v%0d_ack_seen", idx), 128'(got), 128'(1'b1));
    checkOutput($sformatf("v%0d_latency", idx), 128'(lat), 128'(v.exp_lat));
    checkOutput($sformatf("v%0d_mov_cycles", idx), 128'(mov), 128'(v.exp_mov));
    checkOutput($sformatf("v%0d_mov_low_ack", idx), 128'(mem_mov), 128'(1'b0));
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_mov_low_done", idx), 128'(mem_mov), 128'(1'b0));
    checkOutput($sformatf("v%0d_busy_d", idx), 128'(busy_d), 128'(v.port_d));
    checkOutput($sformatf("v%0d_sb_drained", idx), 128'(sb_q.size()), 128'(0));
  endtask

  initial begin
    int         acks;
    int         grants;
    int         cyc;
    int         last_grant;
    bit         prev_mov;
    bit         reraise;
    bit         got;
    logic [2:0] exp_order;

    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem", 128'({mem_mov, mem_rw, mem_size, mem_addr, mem_wdata}), 128'(0));
    checkOutput("rst_rdata", 128'({i_rdata, d_rdata}), 128'(0));
    checkOutput("rst_flags", 128'({i_ack, d_ack, err, busy_d}), 128'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Tie after reset: fetch first; fetch re-requests against pending data,
    // so data wins that tie, then fetch.
    use_fixed = 1'b0;
    moc_delay = 0;
    sb_q.push_back('{1'b0, ram_fn(32'h80), 1'b0});
    sb_q.push_back('{1'b1, ram_fn(32'h300), 1'b0});
    sb_q.push_back('{1'b0, ram_fn(32'h84), 1'b0});
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_rw = RW_READ; d_size = SZ_WORD; d_addr = 32'h300; d_wdata = 32'h55;
    exp_order  = 3'b010;
    acks       = 0;
    grants     = 0;
    cyc        = 0;
    last_grant = 0;
    prev_mov   = 1'b0;
    reraise    = 1'b0;
    while (acks < 3 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (reraise) begin
        i_req = 1'b1; i_addr = 32'h84; reraise = 1'b0;
      end
      if (mem_mov && !prev_mov) begin
        if (grants < 3) checkOutput($sformatf("tie_grant%0d_port", grants), 128'(busy_d), 128'(exp_order[grants]));
        if (grants > 0) checkOutput($sformatf("tie_spacing%0d", grants), 128'(cyc - last_grant), 128'(3));
        last_grant = cyc;
        grants++;
      end
      prev_mov = mem_mov;
      if (i_ack) begin
        i_req = 1'b0;
        acks++;
        if (acks == 1) reraise = 1'b1;
      end
      if (d_ack) begin
        d_req = 1'b0;
        acks++;
      end
    end
    checkOutput("tie_acks", 128'(acks), 128'(3));
    checkOutput("tie_grants", 128'(grants), 128'(3));
    @(posedge clk);
    #1;

    // Single-access table
    vecs[0] = '{1'b0, RW_READ,  SZ_WORD, 32'h40,  32'h0,        32'h8C220004, 0,   32'h8C220004, 1'b0, 2,  1};
    vecs[1] = '{1'b1, RW_READ,  SZ_WORD, 32'h200, 32'h0,        32'h12345678, 2,   32'h12345678, 1'b0, 4,  3};
    vecs[2] = '{1'b1, RW_WRITE, SZ_HALF, 32'h102, 32'hBEEF,     32'h77777777, 1,   32'h12345678, 1'b0, 3,  2};
    vecs[3] = '{1'b1, RW_READ,  SZ_BYTE, 32'h103, 32'h0,        32'h000000AB, 0,   32'h000000AB, 1'b0, 2,  1};
    vecs[4] = '{1'b0, RW_READ,  SZ_WORD, 32'h48,  32'h0,        32'hDEADBEEF, 999, 32'h8C220004, 1'b1, 16, 15};
    vecs[5] = '{1'b1, RW_READ,  SZ_WORD, 32'h204, 32'h0,        32'hCAFEF00D, 14,  32'hCAFEF00D, 1'b0, 16, 15};
    vecs[6] = '{1'b1, RW_WRITE, SZ_WORD, 32'h208, 32'h11223344, 32'h99999999, 999, 32'hCAFEF00D, 1'b1, 16, 15};
    vecs[7] = '{1'b0, RW_READ,  SZ_WORD, 32'h44,  32'h0,        32'h00000013, 3,   32'h00000013, 1'b0, 5,  4};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset during BUSY: MOV drops at once, no ack; pending req then served.
    use_fixed = 1'b1;
    ram_word  = 32'h600DF00D;
    moc_delay = 999;
    d_req = 1'b1; d_rw = RW_READ; d_size = SZ_WORD; d_addr = 32'h400; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mid_busy", 128'(mem_mov), 128'(1'b1));
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_mov_drop", 128'(mem_mov), 128'(1'b0));
    checkOutput("rst_mid_flags", 128'({i_ack, d_ack, err, busy_d}), 128'(0));
    checkOutput("rst_mid_latched", 128'({mem_rw, mem_size, mem_addr}), 128'(0));
    moc_delay = 0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_no_ack", 128'({i_ack, d_ack, err, mem_mov}), 128'(0));
    reset = 1'b1;
    sb_q.push_back('{1'b1, 32'h600DF00D, 1'b0});
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (d_ack || i_ack) got = 1'b1;
    end
    checkOutput("rst_post_ack_seen", 128'(got), 128'(1'b1));
    checkOutput("rst_post_latency", 128'(cyc), 128'(2));
    checkOutput("rst_post_busy_d", 128'(busy_d), 128'(1'b1));
    d_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_post_sb_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
